ysyx_22041211_ifu: RTL and testbench

YSYX_22041211_IFU -- requirements
Module: ysyx_22041211_ifu

---
 rtl/ysyx_22041211_ifu_if.sv | 30 +++
 rtl/ysyx_22041211_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, pipeline redirect
// and the decoded-side instruction handoff.
interface ysyx_22041211_ifu_if #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [ADDR_LEN-1:0] imem_req_addr;
  logic                imem_rsp_valid;
  logic [DATA_LEN-1:0] imem_rsp_data;
  logic                redirect_valid;
  logic [ADDR_LEN-1:0] redirect_pc;
  logic                inst_valid;
  logic                inst_ready;
  logic [DATA_LEN-1:0] inst_o;
  logic [ADDR_LEN-1:0] inst_pc_o;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_pc_o,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_pc_o,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a DEPTH-entry prefetch
// queue, with same-cycle flush and in-flight response dropping on redirect.
module ysyx_22041211_ifu #(
  parameter int unsigned       ADDR_LEN = 32,
  parameter int unsigned       DATA_LEN = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(32'h8000_0000)
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_22041211_ifu_if.master  bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [ADDR_LEN-1:0] pc_mem_q   [DEPTH];
  logic [DATA_LEN-1:0] data_mem_q [DEPTH];

  logic            redirect;
  logic            push;
  logic            pop;
  logic            outstanding;
  logic [CntW-1:0] occupancy;
  logic            unused_redirect_lsb;

  assign redirect            = bus.redirect_valid;
  assign outstanding         = (state_q == StWait);
  assign occupancy           = count_q + CntW'(outstanding);
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign bus.imem_req_addr = fetch_pc_q;
  assign bus.inst_valid    = (count_q != '0) & ~redirect;
  assign bus.inst_o        = data_mem_q[rd_ptr_q];
  assign bus.inst_pc_o     = pc_mem_q[rd_ptr_q];
  assign pop               = bus.inst_valid & bus.inst_ready;

  always_comb begin
    state_d            = state_q;
    fetch_pc_d         = fetch_pc_q;
    push               = 1'b0;
    bus.imem_req_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!redirect && (occupancy < CntW'(DEPTH))) state_d = StReq;
      end
      StReq: begin
        bus.imem_req_valid = 1'b1;
        // An accepted request must still have its response swallowed.
        if (redirect)                state_d = bus.imem_req_ready ? StDrop : StIdle;
        else if (bus.imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (redirect) begin
          state_d = bus.imem_rsp_valid ? StIdle : StDrop;
        end else if (bus.imem_rsp_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
          state_d    = StIdle;
        end
      end
      StDrop: begin
        if (bus.imem_rsp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (redirect) fetch_pc_d = {bus.redirect_pc[ADDR_LEN-1:2], 2'b00};
  end

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
          data_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
          wr_ptr_q             <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Occupancy gating in StIdle must keep the queue from ever overflowing.
  assert property (@(posedge clk) disable iff (rst) !(push && (count_q == CntW'(DEPTH))));

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Scoreboard bench for ysyx_22041211_ifu: directed scenarios queue expected request
// addresses and instructions; a negedge monitor pops and compares on every handshake.
module tb_ysyx_22041211_ifu;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22041211_ifu_if #(.ADDR_LEN(AW), .DATA_LEN(DW)) bus ();

  ysyx_22041211_ifu #(
    .ADDR_LEN(AW), .DATA_LEN(DW), .DEPTH(4), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_req_q  [$];
  logic [63:0] exp_inst_q [$];

  int          grants_left = 0;
  int          rsp_left    = 0;
  bit          pend_hs     = 1'b0;
  logic [31:0] pend_addr   = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every request or instruction handshake is compared against the scoreboard.
  always @(negedge clk) begin
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      if (exp_req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req: got addr %h, expected no request", bus.imem_req_addr);
      end else begin
        check("req_addr", {32'h0, bus.imem_req_addr}, {32'h0, exp_req_q.pop_front()});
      end
      pend_hs   = 1'b1;
      pend_addr = bus.imem_req_addr;
      if (grants_left > 0) grants_left--;
    end
    if (bus.inst_valid && bus.inst_ready) begin
      if (exp_inst_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst: got pc %h data %h, expected no instruction",
                 bus.inst_pc_o, bus.inst_o);
      end else begin
        check("inst_pc_data", {bus.inst_pc_o, bus.inst_o}, exp_inst_q.pop_front());
      end
    end
  end

  // Memory model: one-cycle response to each accepted request while rsp_left allows.
  task automatic tick();
    @(posedge clk);
    #2;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (pend_hs && rsp_left > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_addr);
      pend_hs            = 1'b0;
      rsp_left--;
    end
    bus.imem_req_ready = (grants_left > 0);
  endtask

  task automatic set_mem(input int g, input int r);
    grants_left        = g;
    rsp_left           = r;
    bus.imem_req_ready = (g > 0);
  endtask

  task automatic expect_fetch(input logic [31:0] pc, input bit with_inst);
    exp_req_q.push_back(pc);
    if (with_inst) exp_inst_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_req_q.size() != 0 || exp_inst_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(exp_req_q.size() + exp_inst_q.size()), 64'd0);
    exp_req_q.delete();
    exp_inst_q.delete();
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    pend_hs            = 1'b0;
    set_mem(0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    tick();
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_req_addr",  64'(bus.imem_req_addr),  64'h8000_0000);
    check("rst_inst_valid", 64'(bus.inst_valid),    64'd0);
    check("rst_inst_o",    64'(bus.inst_o),         64'd0);
    check("rst_inst_pc_o", 64'(bus.inst_pc_o),      64'd0);
    tick();
    rst = 1'b0;

    // Sequential fetch, always-ready memory, decoder always ready.
    bus.inst_ready = 1'b1;
    expect_fetch(32'h8000_0000, 1'b1);
    expect_fetch(32'h8000_0004, 1'b1);
    expect_fetch(32'h8000_0008, 1'b1);
    set_mem(3, 3);
    wait_drain("seq_drain", 40);
    tick();
    tick();
    check("stall_req", {31'h0, bus.imem_req_valid, bus.imem_req_addr}, {31'h0, 1'b1, 32'h8000_000C});

    // Decoder stalled: exactly DEPTH fetches, then hold until the decoder drains.
    do_reset();
    for (int i = 0; i < 4; i++) expect_fetch(32'h8000_0000 + 32'(4 * i), 1'b0);
    set_mem(10, 10);
    wait_drain("fill_drain", 60);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check("full_hold", {62'h0, bus.imem_req_valid, bus.inst_valid}, 64'd1);
      tick();
    end
    check("full_head_pc", 64'(bus.inst_pc_o), 64'h8000_0000);
    for (int i = 0; i < 4; i++) exp_inst_q.push_back({32'h8000_0000 + 32'(4 * i),
                                                      mem_word(32'h8000_0000 + 32'(4 * i))});
    expect_fetch(32'h8000_0010, 1'b1);
    set_mem(1, 1);
    bus.inst_ready = 1'b1;
    wait_drain("resume_drain", 60);

    // Redirect while waiting: flush, drop the old response, refetch at aligned target.
    do_reset();
    expect_fetch(32'h8000_0000, 1'b0);
    expect_fetch(32'h8000_0004, 1'b0);
    expect_fetch(32'h8000_0008, 1'b0);
    set_mem(3, 2);
    wait_drain("pre_redir_drain", 40);
    check("pre_redir_valid", 64'(bus.inst_valid), 64'd1);
    check("pre_redir_head",  64'(bus.inst_pc_o),  64'h8000_0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    #1;
    check("redir_masks_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    pend_hs            = 1'b0;
    check("redir_flushed", 64'(bus.inst_valid), 64'd0);
    tick();
    tick();
    check("drop_no_req", 64'(bus.imem_req_valid), 64'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.inst_ready = 1'b1;
    expect_fetch(32'h8000_0100, 1'b1);
    set_mem(1, 1);
    wait_drain("post_redir_drain", 40);

    // Redirect coincident with a would-be pop and a response.
    do_reset();
    expect_fetch(32'h8000_0000, 1'b0);
    expect_fetch(32'h8000_0004, 1'b0);
    set_mem(2, 1);
    wait_drain("pre_coinc_drain", 40);
    check("pre_coinc_valid", 64'(bus.inst_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    bus.inst_ready     = 1'b1;
    pend_hs            = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = mem_word(32'h8000_0004);
    #1;
    check("coinc_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    check("coinc_flushed", 64'(bus.inst_valid), 64'd0);
    expect_fetch(32'h8000_0200, 1'b1);
    set_mem(1, 1);
    wait_drain("post_coinc_drain", 40);

    // Address wrap at the top of the address space.
    do_reset();
    tick();
    tick();
    tick();
    check("pre_wrap_req", {31'h0, bus.imem_req_valid, bus.imem_req_addr}, {31'h0, 1'b1, 32'h8000_0000});
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    check("withdrawn_req", {31'h0, bus.imem_req_valid, bus.imem_req_addr}, {31'h0, 1'b0, 32'hFFFF_FFFC});
    bus.inst_ready = 1'b1;
    expect_fetch(32'hFFFF_FFFC, 1'b1);
    expect_fetch(32'h0000_0000, 1'b1);
    set_mem(2, 2);
    wait_drain("wrap_drain", 40);

    // Reset during WAIT, then a stale response afterwards.
    do_reset();
    expect_fetch(32'h8000_0000, 1'b0);
    set_mem(1, 0);
    wait_drain("pre_rst_drain", 40);
    tick();
    rst     = 1'b1;
    pend_hs = 1'b0;
    #1;
    check("async_rst", {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr}, {2'b00, 32'h8000_0000});
    tick();
    rst                = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    check("stale_ignored", 64'(bus.inst_valid), 64'd0);
    bus.inst_ready = 1'b1;
    expect_fetch(32'h8000_0000, 1'b1);
    set_mem(1, 1);
    wait_drain("post_rst_drain", 40);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
